ex_mem_pipe: RTL and testbench

EX/MEM pipeline register feeding the memory stage, which consumes its address, store data, read/write strobes and BHW code.
- Adds valid tracking, stall/flush handling and misaligned-access detection.
- Provides a halt/exception FSM that freezes the pipeline for the debug unit.
- Latency: one cycle from EX to the memory-stage inputs.

---
 rtl/ex_mem_pkg.sv | 13 +
 rtl/ex_mem_pipe_align_check.sv | 16 +
 rtl/ex_mem_pipe.sv | 131 +++++++++++++
 tb/tb_ex_mem_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared BHW encodings and halt/exception FSM states for the EX/MEM stage
package ex_mem_pkg;
    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_W  = 3'b011;
    localparam logic [2:0] BHW_BU = 3'b100;
    localparam logic [2:0] BHW_HU = 3'b101;
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_EXC    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;
endpackage

// File: rtl/ex_mem_pipe_align_check.sv
// align_check: flags a memory access whose address is not aligned to its BHW access size
module align_check
    import ex_mem_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] bhw,
    input  logic       read,
    input  logic       write,
    output logic       misaligned
);
    // halfwords need addr[0]=0, words need addr[1:0]=0, bytes are always aligned
    always_comb
        misaligned = (read | write) &
                     ((bhw == BHW_H || bhw == BHW_HU) ? addr[0] :
                      (bhw == BHW_W)                  ? |addr   : 1'b0);
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with stall/flush, misalignment trap and halt FSM
// Optional: define EX_MEM_PERF_CNT_EN to add saturating load/store counters o_load_cnt/o_store_cnt.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int NB_WIDTH = 32,
    parameter int NB_REG   = 5
`ifdef EX_MEM_PERF_CNT_EN
    ,
    parameter int NB_CNT   = 16
`endif
)(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_WIDTH-1:0] i_alu_result,
    input  logic [NB_WIDTH-1:0] i_rt_data,
    input  logic [NB_REG-1:0]   i_rd_addr,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [2:0]          i_bhw,
    input  logic                i_reg_write,
    input  logic                i_mem_to_reg,
    input  logic                i_halt,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_exc_clr,
    input  logic                i_resume,
    output logic                o_valid,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_reg_write,
    output logic                o_mem_to_reg,
    output logic [NB_WIDTH-1:0] o_alu_result,
    output logic [NB_WIDTH-1:0] o_store_data,
    output logic [NB_REG-1:0]   o_rd_addr,
    output logic [2:0]          o_bhw,
    output logic                o_stall_req,
    output logic                o_halted,
    output logic                o_exc,
    output logic [NB_WIDTH-1:0] o_exc_addr
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [NB_CNT-1:0]   o_load_cnt,
    output logic [NB_CNT-1:0]   o_store_cnt
`endif
);
    state_t state;
    logic   mis_raw;
    logic   mis;
    logic   ld;

    align_check u_align (
        .addr       (i_alu_result[1:0]),
        .bhw        (i_bhw),
        .read       (i_mem_read),
        .write      (i_mem_write),
        .misaligned (mis_raw)
    );

    assign mis         = i_valid & mis_raw;
    assign ld          = ~i_flush & ~i_stall & (state == ST_RUN);
    assign o_stall_req = (state != ST_RUN);
    assign o_halted    = (state == ST_HALTED);

    // pipeline register: flush clears controls only, frozen/stalled holds, otherwise load gated controls
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid      <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_alu_result <= '0;
            o_store_data <= '0;
            o_rd_addr    <= '0;
            o_bhw        <= '0;
        end else if (i_flush) begin
            o_valid      <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
        end else if (ld) begin
            o_valid      <= i_valid;
            o_mem_read   <= i_valid & i_mem_read & ~mis;
            o_mem_write  <= i_valid & i_mem_write & ~mis;
            o_reg_write  <= i_valid & i_reg_write & ~mis;
            o_mem_to_reg <= i_valid & i_mem_to_reg;
            o_alu_result <= i_alu_result;
            o_store_data <= i_rt_data;
            o_rd_addr    <= i_rd_addr;
            o_bhw        <= i_bhw;
        end
    end

    // halt/exception FSM with sticky exception flag; a misaligned access beats a halt in the same instruction
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_RUN;
            o_exc      <= 1'b0;
            o_exc_addr <= '0;
        end else if (ld && mis) begin
            state      <= ST_EXC;
            o_exc      <= 1'b1;
            o_exc_addr <= i_alu_result;
        end else if (ld && i_valid && i_halt) begin
            state <= ST_HALTED;
        end else if (state == ST_EXC && i_exc_clr) begin
            state <= ST_RUN;
            o_exc <= 1'b0;
        end else if (state == ST_HALTED && i_resume) begin
            state <= ST_RUN;
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    // saturating counters of loaded valid aligned loads and stores
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_load_cnt  <= '0;
            o_store_cnt <= '0;
        end else begin
            if (ld && i_valid && i_mem_read && !mis && !(&o_load_cnt))
                o_load_cnt <= o_load_cnt + 1'b1;
            if (ld && i_valid && i_mem_write && !mis && !(&o_store_cnt))
                o_store_cnt <= o_store_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed plus random checks of ex_mem_pipe against an access-size reference model
module tb_ex_mem_pipe;
    localparam int W = 32;
    localparam int R = 5;
`ifdef EX_MEM_PERF_CNT_EN
    localparam int C = 4;
`else
    localparam int C = 16;
`endif
    localparam int CMAX = (1 << C) - 1;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_alu_result = '0;
    logic [W-1:0] i_rt_data = '0;
    logic [R-1:0] i_rd_addr = '0;
    logic         i_mem_read = 1'b0;
    logic         i_mem_write = 1'b0;
    logic [2:0]   i_bhw = '0;
    logic         i_reg_write = 1'b0;
    logic         i_mem_to_reg = 1'b0;
    logic         i_halt = 1'b0;
    logic         i_stall = 1'b0;
    logic         i_flush = 1'b0;
    logic         i_exc_clr = 1'b0;
    logic         i_resume = 1'b0;
    logic         o_valid, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg;
    logic [W-1:0] o_alu_result, o_store_data, o_exc_addr;
    logic [R-1:0] o_rd_addr;
    logic [2:0]   o_bhw;
    logic         o_stall_req, o_halted, o_exc;
`ifdef EX_MEM_PERF_CNT_EN
    logic [C-1:0] o_load_cnt, o_store_cnt;
`endif

    ex_mem_pipe #(
        .NB_WIDTH (W),
        .NB_REG   (R)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .NB_CNT   (C)
`endif
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_alu_result (i_alu_result),
        .i_rt_data    (i_rt_data),
        .i_rd_addr    (i_rd_addr),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_bhw        (i_bhw),
        .i_reg_write  (i_reg_write),
        .i_mem_to_reg (i_mem_to_reg),
        .i_halt       (i_halt),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_exc_clr    (i_exc_clr),
        .i_resume     (i_resume),
        .o_valid      (o_valid),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_reg_write  (o_reg_write),
        .o_mem_to_reg (o_mem_to_reg),
        .o_alu_result (o_alu_result),
        .o_store_data (o_store_data),
        .o_rd_addr    (o_rd_addr),
        .o_bhw        (o_bhw),
        .o_stall_req  (o_stall_req),
        .o_halted     (o_halted),
        .o_exc        (o_exc),
        .o_exc_addr   (o_exc_addr)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .o_load_cnt   (o_load_cnt),
        .o_store_cnt  (o_store_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    logic         e_valid, e_rd, e_wr, e_rw, e_m2r;
    logic [W-1:0] e_alu, e_sd, e_exc_addr;
    logic [R-1:0] e_rdaddr;
    logic [2:0]   e_bhw;
    logic         m_exc, m_halt;
    int           lcnt, scnt;

    function automatic int access_size(input logic [2:0] b);
        return (b == 3'b011) ? 4 : (b == 3'b001 || b == 3'b101) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {e_valid, e_rd, e_wr, e_rw, e_m2r} = '0;
        e_alu = '0; e_sd = '0; e_exc_addr = '0; e_rdaddr = '0; e_bhw = '0;
        m_exc = 1'b0; m_halt = 1'b0; lcnt = 0; scnt = 0;
    endtask

    task automatic check_all();
        chk("valid", o_valid, e_valid);
        chk("mem_read", o_mem_read, e_rd);
        chk("mem_write", o_mem_write, e_wr);
        chk("reg_write", o_reg_write, e_rw);
        chk("mem_to_reg", o_mem_to_reg, e_m2r);
        chk("alu_result", o_alu_result, e_alu);
        chk("store_data", o_store_data, e_sd);
        chk("rd_addr", o_rd_addr, e_rdaddr);
        chk("bhw", o_bhw, e_bhw);
        chk("stall_req", o_stall_req, m_exc | m_halt);
        chk("halted", o_halted, m_halt);
        chk("exc", o_exc, m_exc);
        chk("exc_addr", o_exc_addr, e_exc_addr);
`ifdef EX_MEM_PERF_CNT_EN
        chk("load_cnt", o_load_cnt, lcnt);
        chk("store_cnt", o_store_cnt, scnt);
`endif
    endtask

    // advance the reference model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic pe, ph, mis;
        pe = m_exc;
        ph = m_halt;
        if (i_flush) begin
            {e_valid, e_rd, e_wr, e_rw, e_m2r} = '0;
        end else if (!(i_stall || pe || ph)) begin
            mis = i_valid && (i_mem_read || i_mem_write) && (int'(i_alu_result % access_size(i_bhw)) != 0);
            e_valid  = i_valid;
            e_rd     = i_valid && i_mem_read && !mis;
            e_wr     = i_valid && i_mem_write && !mis;
            e_rw     = i_valid && i_reg_write && !mis;
            e_m2r    = i_valid && i_mem_to_reg;
            e_alu    = i_alu_result;
            e_sd     = i_rt_data;
            e_rdaddr = i_rd_addr;
            e_bhw    = i_bhw;
            if (i_valid && !mis && i_mem_read && lcnt < CMAX) lcnt++;
            if (i_valid && !mis && i_mem_write && scnt < CMAX) scnt++;
            if (mis) begin
                m_exc = 1'b1;
                e_exc_addr = i_alu_result;
            end else if (i_valid && i_halt) begin
                m_halt = 1'b1;
            end
        end
        if (pe && i_exc_clr) m_exc = 1'b0;
        if (ph && i_resume) m_halt = 1'b0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] b,
                         input logic [W-1:0] a, input logic [W-1:0] d);
        i_valid = v; i_mem_read = r; i_mem_write = w; i_bhw = b;
        i_alu_result = a; i_rt_data = d; i_rd_addr = R'($urandom);
        i_reg_write = r; i_mem_to_reg = r;
        i_halt = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_exc_clr = 1'b0; i_resume = 1'b0;
    endtask

    task automatic rand_instr();
        logic [2:0] codes [5];
        codes = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
        i_valid      = ($urandom_range(3) != 0);
        i_mem_read   = $urandom_range(1);
        i_mem_write  = ~i_mem_read & 1'($urandom_range(1));
        i_bhw        = codes[$urandom_range(4)];
        i_alu_result = W'($urandom_range(255));
        i_rt_data    = $urandom;
        i_rd_addr    = R'($urandom);
        i_reg_write  = $urandom_range(1);
        i_mem_to_reg = $urandom_range(1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all();
        i_reset = 1'b1;

        drive(1, 1, 0, 3'b011, 32'h10, 32'hDEADBEEF);
        cyc();
        chk("lw_read", o_mem_read, 1);
        chk("lw_bhw", o_bhw, 3'b011);
        chk("lw_addr", o_alu_result, 32'h10);
        chk("lw_data", o_store_data, 32'hDEADBEEF);

        drive(1, 0, 1, 3'b011, 32'h12, 32'h1234);
        cyc();
        chk("sw_mis_wr", o_mem_write, 0);
        chk("sw_mis_exc", o_exc, 1);
        chk("sw_mis_addr", o_exc_addr, 32'h12);
        chk("sw_mis_stall", o_stall_req, 1);
        for (int k = 0; k < 3; k++) begin
            rand_instr();
            cyc();
            chk("exc_hold_addr", o_alu_result, 32'h12);
        end
        drive(1, 1, 0, 3'b000, 32'h21, 32'h5);
        i_exc_clr = 1'b1;
        cyc();
        chk("exc_clr", o_exc, 0);
        i_exc_clr = 1'b0;
        cyc();
        chk("after_clr_load", o_alu_result, 32'h21);

        drive(1, 1, 0, 3'b001, 32'h3, 32'h0);
        cyc();
        chk("lh_mis", o_exc, 1);
        i_exc_clr = 1'b1;
        cyc();
        drive(1, 0, 1, 3'b000, 32'h3, 32'hAB);
        cyc();
        chk("sb_ok_exc", o_exc, 0);
        chk("sb_ok_wr", o_mem_write, 1);

        drive(1, 1, 0, 3'b011, 32'h40, 32'h0);
        cyc();
        drive(1, 0, 1, 3'b011, 32'h80, 32'h99);
        i_stall = 1'b1;
        cyc();
        cyc();
        chk("stall_addr", o_alu_result, 32'h40);
        i_flush = 1'b1;
        cyc();
        chk("flush_valid", o_valid, 0);
        chk("flush_read", o_mem_read, 0);

        drive(1, 0, 0, 3'b011, 32'h100, 32'h0);
        i_halt = 1'b1; i_reg_write = 1'b1;
        cyc();
        chk("halt_halted", o_halted, 1);
        chk("halt_stall", o_stall_req, 1);
        chk("halt_rw", o_reg_write, 1);
        drive(1, 1, 0, 3'b011, 32'h104, 32'h0);
        i_exc_clr = 1'b1;
        cyc();
        chk("halt_ign_clr", o_halted, 1);
        i_exc_clr = 1'b0; i_resume = 1'b1;
        cyc();
        chk("resume", o_halted, 0);
        i_resume = 1'b0;
        cyc();
        chk("resume_load", o_alu_result, 32'h104);

        drive(1, 1, 1, 3'b001, 32'h201, 32'h0);
        i_halt = 1'b1;
        cyc();
        chk("mis_beats_halt_exc", o_exc, 1);
        chk("mis_beats_halt_h", o_halted, 0);
        drive(1, 1, 0, 3'b011, 32'h202, 32'h0);
        i_flush = 1'b1; i_exc_clr = 1'b1;
        cyc();
        drive(1, 1, 0, 3'b011, 32'h206, 32'h0);
        i_flush = 1'b1;
        cyc();
        chk("flush_beats_mis", o_exc, 0);

        drive(1, 0, 0, 3'b000, 32'h300, 32'h0);
        i_halt = 1'b1;
        cyc();
        chk("halt2", o_halted, 1);
        i_reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        i_reset = 1'b1;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        cyc();

`ifdef EX_MEM_PERF_CNT_EN
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 0, 3'b011, W'(k * 4), 32'h0);
            cyc();
        end
        chk("load_cnt_sat", o_load_cnt, 15);
        i_reset = 1'b0;
        #1;
        model_reset();
        #2;
        i_reset = 1'b1;
        drive(1, 1, 0, 3'b011, 32'h8, 32'h0);
        cyc();
        drive(1, 1, 0, 3'b011, 32'h9, 32'h0);
        cyc();
        chk("mis_no_cnt", o_load_cnt, 1);
        drive(1, 1, 0, 3'b011, 32'hC, 32'h0);
        i_exc_clr = 1'b1;
        cyc();
        drive(1, 1, 0, 3'b011, 32'hC, 32'h0);
        cyc();
        i_stall = 1'b1;
        cyc();
        chk("stall_no_dbl", o_load_cnt, 2);
`endif

        for (int k = 0; k < 400; k++) begin
            rand_instr();
            i_halt    = ($urandom_range(9) == 0);
            i_stall   = ($urandom_range(4) == 0);
            i_flush   = ($urandom_range(15) == 0);
            i_exc_clr = ($urandom_range(3) == 0);
            i_resume  = ($urandom_range(3) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
